// File: rtl/hazard_ctrl_unit.sv
// Hazard controller beside decode: cache freeze, branch flush,
// load-use bubble and the cache-switch drain/switch/release sequence.
module hazard_ctrl_unit #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_reg1_read_address,
   input  logic [4:0]       id_reg2_read_address,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_switch_cache_w,
   input  logic             ex_d_mem_r,
   input  logic             ex_write_reg_en,
   input  logic [4:0]       ex_write_address,
   input  logic             branch_jump_signal,
   input  logic             i_busywait,
   input  logic             d_busywait,
   input  logic             switch_ack,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_busywait,
   output logic             id_ex_flush,
   output logic             cache_switch_start,
   output logic [1:0]       hz_state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] switch_count
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      SWITCH  = 2'd2,
      RELEASE = 2'd3
   } hz_st_t;

   hz_st_t     state, state_nx;
   logic [3:0] drain_cnt, drain_nx;
   logic       in_switch_d;
   logic       busy;
   logic       load_use;
   logic       rs1_hit, rs2_hit;

   assign busy    = i_busywait | d_busywait;
   assign rs1_hit = id_uses_rs1 &
                    (id_reg1_read_address == ex_write_address);
   assign rs2_hit = id_uses_rs2 &
                    (id_reg2_read_address == ex_write_address);
   assign load_use = ex_d_mem_r & ex_write_reg_en &
                     (ex_write_address != 5'd0) &
                     (rs1_hit | rs2_hit);
   assign hz_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         drain_cnt   <= 4'd0;
         in_switch_d <= 1'b0;
      end else begin
         state       <= state_nx;
         drain_cnt   <= drain_nx;
         in_switch_d <= (state == SWITCH);
      end
   end

   always_comb begin
      state_nx = state;
      drain_nx = drain_cnt;
      if (!busy) begin
         case (state)
            RUN: begin
               if (!branch_jump_signal && id_switch_cache_w) begin
                  state_nx = DRAIN;
                  drain_nx = 4'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               // a taken branch kills the younger switch instruction
               if (branch_jump_signal) begin
                  state_nx = RUN;
                  drain_nx = 4'd0;
               end else if (drain_cnt <= 4'd1) begin
                  state_nx = SWITCH;
                  drain_nx = 4'd0;
               end else begin
                  drain_nx = drain_cnt - 4'd1;
               end
            end
            SWITCH: begin
               if (switch_ack)
                  state_nx = RELEASE;
            end
            RELEASE: state_nx = RUN;
            default: state_nx = RUN;
         endcase
      end
   end

   always_comb begin
      pc_stall           = 1'b0;
      if_id_stall        = 1'b0;
      if_id_flush        = 1'b0;
      id_ex_busywait     = 1'b0;
      id_ex_flush        = 1'b0;
      cache_switch_start = 1'b0;
      if (!reset) begin
         pc_stall = 1'b0;
      end else if (busy) begin
         pc_stall       = 1'b1;
         if_id_stall    = 1'b1;
         id_ex_busywait = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (branch_jump_signal) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (id_switch_cache_w || load_use) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            DRAIN: begin
               if (branch_jump_signal) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            SWITCH: begin
               pc_stall           = 1'b1;
               if_id_stall        = 1'b1;
               id_ex_flush        = 1'b1;
               cache_switch_start = ~in_switch_d;
            end
            default: pc_stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count  <= '0;
         switch_count <= '0;
      end else begin
         if (pc_stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
         if ((state == SWITCH) && !busy && switch_ack &&
             (switch_count != '1))
            switch_count <= switch_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: vector table in RUN,
// then busy/branch, switch, drain abort, busy-in-drain and reset.
module tb_hazard_ctrl_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1, rs2, wa;
   logic        u1, u2, sw, ld, wen, br, ibw, dbw, ack;
   logic        pc_stall, if_id_stall, if_id_flush;
   logic        id_ex_busywait, id_ex_flush, cache_switch_start;
   logic [1:0]  hz_state;
   logic [15:0] stall_count, switch_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
      .clk                  (clk),
      .reset                (reset),
      .id_reg1_read_address (rs1),
      .id_reg2_read_address (rs2),
      .id_uses_rs1          (u1),
      .id_uses_rs2          (u2),
      .id_switch_cache_w    (sw),
      .ex_d_mem_r           (ld),
      .ex_write_reg_en      (wen),
      .ex_write_address     (wa),
      .branch_jump_signal   (br),
      .i_busywait           (ibw),
      .d_busywait           (dbw),
      .switch_ack           (ack),
      .pc_stall             (pc_stall),
      .if_id_stall          (if_id_stall),
      .if_id_flush          (if_id_flush),
      .id_ex_busywait       (id_ex_busywait),
      .id_ex_flush          (id_ex_flush),
      .cache_switch_start   (cache_switch_start),
      .hz_state             (hz_state),
      .stall_count          (stall_count),
      .switch_count         (switch_count)
   );

   typedef struct {
      logic       ibw, dbw, br, ld, wen;
      logic [4:0] wa, rs1, rs2;
      logic       u1, u2;
      logic [4:0] exp;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   function automatic logic [4:0] ctl();
      return {pc_stall, if_id_stall, if_id_flush,
              id_ex_busywait, id_ex_flush};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; wa = 0; u1 = 0; u2 = 0; sw = 0;
      ld = 0; wen = 0; br = 0; ibw = 0; dbw = 0; ack = 0;
   endtask

   initial begin
      int dc;
      // {ibw,dbw,br,ld,wen,wa,rs1,rs2,u1,u2,{pc,ifs,iff,ideb,idf}}
      vt[0]  = '{0,0,0,0,0, 0, 0, 0,0,0, 5'b00000};
      vt[1]  = '{0,0,0,1,1, 5, 1, 5,0,1, 5'b11001};
      vt[2]  = '{0,0,0,1,1, 0, 0, 0,1,1, 5'b00000};
      vt[3]  = '{0,0,0,1,1, 5, 5, 2,1,0, 5'b11001};
      vt[4]  = '{0,0,0,1,1, 5, 5, 2,0,0, 5'b00000};
      vt[5]  = '{0,0,0,0,1, 5, 1, 5,0,1, 5'b00000};
      vt[6]  = '{0,0,0,1,0, 5, 1, 5,0,1, 5'b00000};
      vt[7]  = '{0,0,1,0,0, 0, 0, 0,0,0, 5'b00101};
      vt[8]  = '{0,0,1,1,1, 5, 5, 5,1,1, 5'b00101};
      vt[9]  = '{0,1,0,1,1, 5, 5, 5,1,1, 5'b11010};
      vt[10] = '{1,0,1,0,0, 0, 0, 0,0,0, 5'b11010};
      vt[11] = '{0,0,0,1,1, 5, 1, 6,1,1, 5'b00000};

      idle();
      reset = 1'b0;
      tick();
      tick();
      chk("reset_ctl", 32'(ctl()), 0);
      chk("reset_state", 32'(hz_state), 0);
      chk("reset_stallcnt", 32'(stall_count), 0);
      chk("reset_swcnt", 32'(switch_count), 0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         ibw = vt[i].ibw; dbw = vt[i].dbw; br = vt[i].br;
         ld = vt[i].ld; wen = vt[i].wen; wa = vt[i].wa;
         rs1 = vt[i].rs1; rs2 = vt[i].rs2;
         u1 = vt[i].u1; u2 = vt[i].u2;
         #1;
         chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vt[i].exp));
         chk($sformatf("vec%0d_start", i),
             32'(cache_switch_start), 0);
         tick();
         chk($sformatf("vec%0d_state", i), 32'(hz_state), 0);
      end
      idle();
      #1;
      chk("table_stallcnt", 32'(stall_count), 4);

      // branch held across a data-cache freeze
      dbw = 1; br = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("busy%0d_ctl", i), 32'(ctl()), 5'b11010);
         tick();
      end
      dbw = 0;
      #1;
      chk("busy_branch_ctl", 32'(ctl()), 5'b00101);
      tick();
      br = 0;
      chk("busy_stallcnt", 32'(stall_count), 8);

      // full switch, instruction held in ID through RELEASE
      sw = 1;
      #1;
      chk("sw_entry_ctl", 32'(ctl()), 5'b11001);
      chk("sw_entry_state", 32'(hz_state), 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("drain%0d_state", i), 32'(hz_state), 1);
         chk($sformatf("drain%0d_ctl", i), 32'(ctl()), 5'b11001);
         chk($sformatf("drain%0d_start", i),
             32'(cache_switch_start), 0);
         tick();
      end
      chk("sw1_state", 32'(hz_state), 2);
      chk("sw1_start", 32'(cache_switch_start), 1);
      tick();
      chk("sw2_start", 32'(cache_switch_start), 0);
      chk("sw2_ctl", 32'(ctl()), 5'b11001);
      tick();
      tick();
      tick();
      ack = 1;
      #1;
      chk("sw5_state", 32'(hz_state), 2);
      tick();
      ack = 0;
      #1;
      chk("rel_state", 32'(hz_state), 3);
      chk("rel_ctl", 32'(ctl()), 0);
      chk("rel_start", 32'(cache_switch_start), 0);
      tick();
      sw = 0;
      #1;
      chk("sw_done_state", 32'(hz_state), 0);
      chk("sw_done_swcnt", 32'(switch_count), 1);
      chk("sw_done_stallcnt", 32'(stall_count), 17);

      // branch aborts the drain
      sw = 1;
      tick();
      sw = 0;
      tick();
      chk("abort_pre_state", 32'(hz_state), 1);
      br = 1;
      #1;
      chk("abort_ctl", 32'(ctl()), 5'b00101);
      tick();
      br = 0;
      #1;
      chk("abort_state", 32'(hz_state), 0);
      chk("abort_start", 32'(cache_switch_start), 0);
      chk("abort_swcnt", 32'(switch_count), 1);
      chk("abort_stallcnt", 32'(stall_count), 19);

      // instruction-cache freeze mid-drain stretches residency
      sw = 1;
      tick();
      sw = 0;
      dc = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (hz_state != 2'd1) break;
         dc++;
         ibw = (dc == 2 || dc == 3);
         tick();
      end
      ibw = 0;
      #1;
      chk("bdrain_cycles", dc, 5);
      chk("bdrain_state", 32'(hz_state), 2);
      chk("bdrain_start", 32'(cache_switch_start), 1);
      ack = 1;
      tick();
      ack = 0;
      #1;
      chk("bdrain_rel", 32'(hz_state), 3);
      tick();
      chk("bdrain_stallcnt", 32'(stall_count), 26);
      chk("bdrain_swcnt", 32'(switch_count), 2);

      // asynchronous reset while waiting in SWITCH
      sw = 1;
      tick();
      sw = 0;
      tick();
      tick();
      tick();
      chk("rst_pre_state", 32'(hz_state), 2);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_ctl", 32'(ctl()), 0);
      chk("rst_start", 32'(cache_switch_start), 0);
      chk("rst_state", 32'(hz_state), 0);
      chk("rst_stallcnt", 32'(stall_count), 0);
      chk("rst_swcnt", 32'(switch_count), 0);
      tick();
      reset = 1'b1;
      ack = 1;
      #1;
      chk("late_ack_start", 32'(cache_switch_start), 0);
      tick();
      ack = 0;
      #1;
      chk("late_ack_state", 32'(hz_state), 0);
      chk("late_ack_swcnt", 32'(switch_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
